// File: rtl/dfr_dac_pkg.sv
// Shared widths, frame layout and receiver state encoding for the DAC link receiver.
package dfr_dac_pkg;

  localparam int unsigned DAC_CMD_W      = 4;
  localparam int unsigned DAC_ADDR_W     = 4;
  localparam int unsigned DAC_DATA_W     = 16;
  localparam int unsigned DAC_FRAME_BITS = DAC_CMD_W + DAC_ADDR_W + DAC_DATA_W;

  typedef struct packed {
    logic [DAC_CMD_W-1:0]  cmd;
    logic [DAC_ADDR_W-1:0] addr;
    logic [DAC_DATA_W-1:0] data;
  } dac_frame_t;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    CHECK
  } dac_rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous link input, followed by an edge-detect flop.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edges come from the last synchronizer stage against the edge-detect flop.
  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/dac_spi_rx.sv
// Oversampling deframer for the serial DAC link with an LDAC-latched code output.
// Define DAC_RX_STATS_EN to add saturating frame_cnt/err_cnt statistics outputs.
module dac_spi_rx
  import dfr_dac_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = DAC_FRAME_BITS,
  parameter int unsigned CMD_WIDTH   = DAC_CMD_W,
  parameter int unsigned ADDR_WIDTH  = DAC_ADDR_W,
  parameter int unsigned DATA_WIDTH  = DAC_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dac_cs_n,
  input  logic                  dac_sclk,
  input  logic                  dac_din,
  input  logic                  dac_ldac_n,
  output logic                  frame_valid,
  output logic [CMD_WIDTH-1:0]  frame_cmd,
  output logic [ADDR_WIDTH-1:0] frame_addr,
  output logic [DATA_WIDTH-1:0] frame_data,
  output logic                  frame_err,
  output logic [DATA_WIDTH-1:0] dac_code,
  output logic                  dac_update
`ifdef DAC_RX_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           err_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  logic cs_level, cs_rise, cs_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic din_level, din_rise, din_fall;
  logic ldac_level, ldac_rise, ldac_fall;

  dac_rx_state_t          state;
  logic [FRAME_BITS-1:0]  shreg;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   pending;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .async_in(dac_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .async_in(dac_sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk(clk), .rst(rst), .async_in(dac_din),
    .level(din_level), .rise(din_rise), .fall(din_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ldac (
    .clk(clk), .rst(rst), .async_in(dac_ldac_n),
    .level(ldac_level), .rise(ldac_rise), .fall(ldac_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_level, sclk_fall, din_rise, din_fall, ldac_level, ldac_rise};

  // Deframing FSM plus LDAC latch; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      pending     <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cmd   <= '0;
      frame_addr  <= '0;
      frame_data  <= '0;
      dac_code    <= '0;
      dac_update  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      dac_update  <= 1'b0;

      // LDAC applies the frame pending before this cycle; a frame accepted now stays pending.
      if (ldac_fall && pending) begin
        dac_code   <= frame_data;
        dac_update <= 1'b1;
        pending    <= 1'b0;
      end

      case (state)
        WAIT_IDLE: begin
          if (cs_level) state <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= CHECK;
          end else if (sclk_rise) begin
            shreg <= {shreg[FRAME_BITS-2:0], din_level};
            if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          state <= IDLE;
          if (bit_cnt == CNT_FULL) begin
            frame_cmd   <= shreg[FRAME_BITS-1 -: CMD_WIDTH];
            frame_addr  <= shreg[DATA_WIDTH +: ADDR_WIDTH];
            frame_data  <= shreg[DATA_WIDTH-1:0];
            frame_valid <= 1'b1;
            pending     <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

`ifdef DAC_RX_STATS_EN
  // Saturating counts of decoded and rejected windows.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_valid && (frame_cnt != 16'hFFFF)) frame_cnt <= frame_cnt + 16'd1;
      if (frame_err && (err_cnt != 16'hFFFF))     err_cnt   <= err_cnt + 16'd1;
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule
